ls_dma_port: RTL and testbench

//   External-side access port of the SPU local store: the DMA (MFC) end of the LS, complementing the SPU odd-pipe load/store unit.

---
 rtl/ls_dma_port_if.sv | 48 ++++
 rtl/ls_dma_port.sv | 166 ++++++++++++++++
 tb/tb_ls_dma_port.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ls_dma_port_if.sv
// Bus bundle for the local-store DMA port: command, GET/PUT streams, LS access and completion.
// Handshakes: a transfer happens on a cycle where valid && ready; ls access happens iff ls_req && ls_gnt.
interface ls_dma_port_if #(
  parameter int QW_ADDR_W = 11,
  parameter int LEN_W     = 8
);
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic                 cmd_dir;
  logic [0:17]          cmd_lsa;
  logic [0:LEN_W-1]     cmd_len;
  logic [0:4]           cmd_tag;

  logic                 in_valid;
  logic                 in_ready;
  logic [0:127]         in_data;

  logic                 out_valid;
  logic                 out_ready;
  logic [0:127]         out_data;

  logic                 ls_req;
  logic                 ls_we;
  logic [0:QW_ADDR_W-1] ls_addr;
  logic [0:127]         ls_wdata;
  logic                 ls_gnt;
  logic [0:127]         ls_rdata;

  logic                 done_valid;
  logic [0:4]           done_tag;
  logic                 busy;

  // DMA port side
  modport slave (
    input  cmd_valid, cmd_dir, cmd_lsa, cmd_len, cmd_tag,
    input  in_valid, in_data, out_ready, ls_gnt, ls_rdata,
    output cmd_ready, in_ready, out_valid, out_data,
    output ls_req, ls_we, ls_addr, ls_wdata, done_valid, done_tag, busy
  );

  // Environment side (MFC command source, streams, LS arbiter)
  modport master (
    output cmd_valid, cmd_dir, cmd_lsa, cmd_len, cmd_tag,
    output in_valid, in_data, out_ready, ls_gnt, ls_rdata,
    input  cmd_ready, in_ready, out_valid, out_data,
    input  ls_req, ls_we, ls_addr, ls_wdata, done_valid, done_tag, busy
  );
endinterface

// File: rtl/ls_dma_port.sv
// DMA end of the SPU local store: moves quadword blocks between an external stream and the LS
// through a shared, granted LS port. GET writes stream beats into LS, PUT streams LS reads out.
module ls_dma_port #(
  parameter int QW_ADDR_W = 11,
  parameter int LEN_W     = 8,
  parameter int OBUF_D    = 2
) (
  input  logic         clk,
  input  logic         reset,
  ls_dma_port_if.slave bus,
  output logic [2:0]   dbg_state_o
);
  localparam int PW = (OBUF_D > 1) ? $clog2(OBUF_D) : 1;
  localparam int CW = $clog2(OBUF_D + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_GET   = 3'd1,
    S_PUT   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [QW_ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]     rem_q, rem_d;
  logic [4:0]           tag_q, tag_d;
  logic                 inflight_q, inflight_d;

  logic [127:0]         obuf_q [OBUF_D];
  logic [PW-1:0]        rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]        cnt_q;

  logic                 obuf_empty;
  logic                 push;
  logic                 pop;
  logic                 rd_room;
  logic                 rd_req;
  logic                 unused_lsa_bits;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (int'(p) == OBUF_D - 1) ? '0 : p + PW'(1);
  endfunction

  assign obuf_empty = (cnt_q == '0);
  assign push       = inflight_q;
  assign pop        = !obuf_empty && bus.out_ready;
  // A pop this cycle frees a slot, so counting it keeps reads flowing at one QW per cycle.
  assign rd_room    = (int'(cnt_q) + int'(inflight_q) - int'(pop)) < OBUF_D;

  assign bus.out_valid = !obuf_empty;
  assign bus.out_data  = obuf_empty ? '0 : obuf_q[rd_ptr_q];
  assign bus.ls_addr   = addr_q;
  assign bus.busy      = (state_q != S_IDLE);
  assign dbg_state_o   = state_q;

  // Byte-offset bits and index bits above the LS size are don't-care.
  assign unused_lsa_bits = ^{bus.cmd_lsa[0:13-QW_ADDR_W], bus.cmd_lsa[14:17]};

  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    rem_d          = rem_q;
    tag_d          = tag_q;
    inflight_d     = 1'b0;
    rd_req         = 1'b0;
    bus.cmd_ready  = 1'b0;
    bus.in_ready   = 1'b0;
    bus.ls_req     = 1'b0;
    bus.ls_we      = 1'b0;
    bus.ls_wdata   = '0;
    bus.done_valid = 1'b0;
    bus.done_tag   = '0;
    case (state_q)
      S_IDLE: begin
        bus.cmd_ready = !reset;
        if (bus.cmd_valid && !reset) begin
          tag_d  = bus.cmd_tag;
          addr_d = bus.cmd_lsa[14-QW_ADDR_W:13];
          rem_d  = bus.cmd_len;
          if (bus.cmd_len == '0) begin
            state_d = S_DONE;
          end else if (bus.cmd_dir) begin
            state_d = S_PUT;
          end else begin
            state_d = S_GET;
          end
        end
      end
      S_GET: begin
        bus.ls_req   = bus.in_valid;
        bus.ls_we    = 1'b1;
        bus.ls_wdata = bus.in_data;
        bus.in_ready = bus.ls_gnt;
        if (bus.in_valid && bus.ls_gnt) begin
          addr_d = addr_q + QW_ADDR_W'(1);
          rem_d  = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) begin
            state_d = S_DONE;
          end
        end
      end
      S_PUT: begin
        rd_req     = (rem_q != '0) && rd_room;
        bus.ls_req = rd_req;
        if (rd_req && bus.ls_gnt) begin
          addr_d     = addr_q + QW_ADDR_W'(1);
          rem_d      = rem_q - LEN_W'(1);
          inflight_d = 1'b1;
          if (rem_q == LEN_W'(1)) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        // Finish once the last read has landed and its beat leaves the buffer.
        if (!inflight_q && (obuf_empty || (cnt_q == CW'(1) && pop))) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        bus.done_valid = 1'b1;
        bus.done_tag   = tag_q;
        state_d        = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      rem_q      <= '0;
      tag_q      <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      tag_q      <= tag_d;
      inflight_q <= inflight_d;
    end
  end

  // PUT output FIFO; ls_rdata is captured the cycle after its granted read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < OBUF_D; i++) begin
        obuf_q[i] <= '0;
      end
    end else begin
      if (push) begin
        obuf_q[wr_ptr_q] <= bus.ls_rdata;
        wr_ptr_q         <= ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      cnt_q <= cnt_q + CW'(push) - CW'(pop);
    end
  end
endmodule

// File: tb/tb_ls_dma_port.sv
// Directed and randomized bench for ls_dma_port: an LS array plus queue-based expectations
// derived from the command (base QW, length, direction) are compared against the port's behaviour.
module tb_ls_dma_port;
  localparam int QW_ADDR_W = 11;
  localparam int LEN_W     = 8;
  localparam int OBUF_D    = 2;
  localparam int LS_QW     = 1 << QW_ADDR_W;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] dbg_state;
  int         n_vec = 0;
  int         n_err = 0;

  logic [127:0] ls_mem [LS_QW];

  ls_dma_port_if #(.QW_ADDR_W(QW_ADDR_W), .LEN_W(LEN_W)) bus ();

  ls_dma_port #(.QW_ADDR_W(QW_ADDR_W), .LEN_W(LEN_W), .OBUF_D(OBUF_D)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_cmd_ready"},  bus.cmd_ready, 0);
    chk({tag, "_in_ready"},   bus.in_ready, 0);
    chk({tag, "_out_valid"},  bus.out_valid, 0);
    chk({tag, "_out_data"},   bus.out_data, 0);
    chk({tag, "_ls_req"},     bus.ls_req, 0);
    chk({tag, "_ls_we"},      bus.ls_we, 0);
    chk({tag, "_ls_addr"},    bus.ls_addr, 0);
    chk({tag, "_done_valid"}, bus.done_valid, 0);
    chk({tag, "_done_tag"},   bus.done_tag, 0);
    chk({tag, "_busy"},       bus.busy, 0);
  endtask

  // gmode: 0 grant always, 1 random grant, 2 grant withheld 3 cycles after beat 2.
  // omode: 0 out_ready/in_valid high, 1 out_ready toggles 1,0,..., 2 random.
  task automatic run_cmd(input bit dir, input logic [17:0] lsa, input int len, input logic [4:0] tag,
                         input int gmode, input int omode, input int abort_beat, input bit seq_data);
    logic [127:0] get_q[$];
    logic [127:0] exp_q[$];
    int base, beats, reads, pops, grants, stall, cyc, budget, pend_addr;
    int last_beat_cyc, first_pop_cyc, last_pop_cyc, exp_done;
    bit pend, done_seen, gnt, active;
    base = 0; beats = 0; reads = 0; pops = 0; grants = 0; stall = 0; cyc = 0;
    last_beat_cyc = 0; first_pop_cyc = 0; last_pop_cyc = 0; pend = 0; done_seen = 0; pend_addr = 0;
    base = int'(lsa[17:4]) % LS_QW;
    for (int i = 0; i < len; i++) begin
      if (!dir) get_q.push_back(seq_data ? 128'(i + 1) : rand128());
      else      exp_q.push_back(ls_mem[(base + i) % LS_QW]);
    end

    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_dir   = dir;
    bus.cmd_lsa   = lsa;
    bus.cmd_len   = LEN_W'(len);
    bus.cmd_tag   = tag;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.ls_gnt    = 1'b1;
    #1 chk("cmd_ready", bus.cmd_ready, 1);
    @(posedge clk);

    budget = 50 + 20 * len;
    while (!done_seen && cyc < budget) begin
      @(negedge clk);
      cyc++;
      bus.cmd_valid = 1'b0;
      bus.cmd_len   = LEN_W'($urandom_range(0, 255));
      bus.ls_rdata  = pend ? ls_mem[pend_addr] : rand128();
      pend = 1'b0;
      case (gmode)
        0:       gnt = 1'b1;
        1:       gnt = ($urandom_range(0, 3) != 0);
        default: begin
          if (beats == 2 && stall < 3) begin
            gnt = 1'b0;
            stall++;
          end else begin
            gnt = 1'b1;
          end
        end
      endcase
      bus.ls_gnt = gnt;
      case (omode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = ((cyc % 2) == 1);
        default: bus.out_ready = 1'($urandom_range(0, 1));
      endcase
      active = !dir && (beats < len);
      if (active) begin
        bus.in_valid = (omode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
        bus.in_data  = get_q[beats];
      end else begin
        bus.in_valid = 1'($urandom_range(0, 1));
        bus.in_data  = rand128();
      end
      if (abort_beat != 0 && pops == abort_beat) begin
        reset = 1'b1;
        #1 check_zero("abort");
        repeat (2) begin
          @(negedge clk);
          chk("abort_no_done", bus.done_valid, 0);
        end
        return;
      end
      #1;
      if (!dir) chk("get_ls_req", bus.ls_req, active ? bus.in_valid : 1'b0);
      else if (reads == len) chk("put_req_after_last", bus.ls_req, 0);
      if (active) begin
        chk("in_ready", bus.in_ready, gnt);
        if (bus.in_valid) begin
          chk("wr_addr", bus.ls_addr, (base + beats) % LS_QW);
          chk("wr_we", bus.ls_we, 1);
          chk("wr_data", bus.ls_wdata, get_q[beats]);
        end
      end else begin
        chk("in_ready_idle", bus.in_ready, 0);
      end
      if (bus.ls_req && gnt) begin
        grants++;
        if (grants > len) begin
          chk("extra_ls_access", grants, len);
        end else if (!dir) begin
          ls_mem[int'(bus.ls_addr)] = bus.ls_wdata;
          beats++;
          last_beat_cyc = cyc;
        end else begin
          chk("rd_we", bus.ls_we, 0);
          chk("rd_addr", bus.ls_addr, (base + reads) % LS_QW);
          pend      = 1'b1;
          pend_addr = int'(bus.ls_addr);
          reads++;
        end
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) chk("extra_out_beat", pops + 1, len);
        else                   chk("out_data", bus.out_data, exp_q.pop_front());
        if (pops == 0) first_pop_cyc = cyc;
        pops++;
        last_pop_cyc = cyc;
      end
      if (bus.done_valid) begin
        chk("done_tag", bus.done_tag, tag);
        chk("done_remaining", dir ? exp_q.size() : len - beats, 0);
        exp_done = (len == 0) ? 1 : (dir ? last_pop_cyc + 1 : last_beat_cyc + 1);
        chk("done_cycle", cyc, exp_done);
        done_seen = 1'b1;
      end
      @(posedge clk);
    end
    if (!done_seen) chk("done_timeout", done_seen, 1);

    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.ls_gnt    = 1'b1;
    #1;
    chk("done_once", bus.done_valid, 0);
    chk("idle_cmd_ready", bus.cmd_ready, 1);
    chk("idle_busy", bus.busy, 0);
    chk("access_count", grants, len);
    if (!dir) begin
      for (int i = 0; i < len; i++) chk("ls_contents", ls_mem[(base + i) % LS_QW], get_q[i]);
    end
    if (dir && gmode == 0 && omode == 0 && len > 1) begin
      chk("put_throughput", last_pop_cyc - first_pop_cyc, len - 1);
    end
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_dir   = 1'b0;
    bus.cmd_lsa   = '0;
    bus.cmd_len   = '0;
    bus.cmd_tag   = '0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    bus.ls_gnt    = 1'b0;
    bus.ls_rdata  = '0;
    for (int i = 0; i < LS_QW; i++) ls_mem[i] = rand128();

    // Reset state, then release
    reset = 1'b1;
    repeat (3) @(negedge clk);
    #1 check_zero("reset");
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("cmd_ready_after_reset", bus.cmd_ready, 1);
    chk("busy_after_reset", bus.busy, 0);

    // GET 1..4 into QW 0x010..0x013
    run_cmd(1'b0, 18'h00100, 4, 5'd3, 0, 0, 0, 1'b1);

    // PUT of preset A,B,C with out_ready toggling
    ls_mem[12'h020] = 128'hAAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA;
    ls_mem[12'h021] = 128'hBBBB_BBBB_BBBB_BBBB_BBBB_BBBB_BBBB_BBBB;
    ls_mem[12'h022] = 128'hCCCC_CCCC_CCCC_CCCC_CCCC_CCCC_CCCC_CCCC;
    run_cmd(1'b1, 18'h00200, 3, 5'd7, 0, 1, 0, 1'b0);

    // GET with grant withheld after beat 2
    run_cmd(1'b0, 18'h01230, 4, 5'd9, 2, 0, 0, 1'b0);

    // Address wrap on PUT and GET (the GET also exercises index truncation)
    run_cmd(1'b1, 18'h07FF0, 2, 5'd11, 0, 0, 0, 1'b0);
    run_cmd(1'b0, 18'h3FFE0, 4, 5'd12, 1, 2, 0, 1'b0);

    // Zero length
    run_cmd(1'b0, 18'h00400, 0, 5'd13, 0, 0, 0, 1'b0);

    // Streaming PUT
    run_cmd(1'b1, 18'h00500, 8, 5'd14, 0, 0, 0, 1'b0);

    // Reset during beat 2 of a 5-beat PUT, then a fresh GET
    run_cmd(1'b1, 18'h00600, 5, 5'd15, 0, 0, 2, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("cmd_ready_after_abort", bus.cmd_ready, 1);
    chk("busy_after_abort", bus.busy, 0);
    run_cmd(1'b0, 18'h00600, 3, 5'd16, 0, 0, 0, 1'b0);

    // Random commands
    for (int k = 0; k < 12; k++) begin
      run_cmd(1'($urandom_range(0, 1)), 18'($urandom()), $urandom_range(0, 12), 5'($urandom()),
              $urandom_range(0, 1), 2 * $urandom_range(0, 1), 0, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
